// File: rtl/secure_bank_reader.sv
// secure_bank_reader: a lock-gated reader for a four-entry register bank.
// Each request yields one beat, or a burst that runs from the start index up
// to entry 3. The lock is sampled at the edge that loads each beat. A beat
// loaded while the lock is set carries zero data, sets rsp_err, and bumps a
// saturating counter of denied beats.
module secure_bank_reader (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lock,
  input  logic [31:0] bank0,
  input  logic [31:0] bank1,
  input  logic [31:0] bank2,
  input  logic [31:0] bank3,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_addr,
  input  logic        req_burst,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_addr,
  output logic        rsp_err,
  output logic        rsp_last,
  output logic [7:0]  err_count
);

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

  state_t      state;
  logic        burst;
  logic        load_en;
  logic [1:0]  load_idx;
  logic        load_burst;
  logic [31:0] load_word;

  // Ready is held low during reset, so nothing is accepted until reset is released.
  assign req_ready = rst_n & (state == IDLE);

  // Pick the beat to load: a new request in IDLE, or the next index on a non-final handshake.
  always_comb begin
    load_en    = 1'b0;
    load_idx   = req_addr;
    load_burst = req_burst;
    if (state == IDLE) begin
      load_en = req_valid;
    end else begin
      load_en    = rsp_ready & ~rsp_last;
      load_idx   = 2'(rsp_addr + 2'd1);
      load_burst = burst;
    end
  end

  // Bank mux for the index being loaded.
  always_comb begin
    case (load_idx)
      2'd0:    load_word = bank0;
      2'd1:    load_word = bank1;
      2'd2:    load_word = bank2;
      default: load_word = bank3;
    endcase
  end

  // FSM plus beat registers. A beat stays frozen until it is handshaken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      burst     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_addr  <= '0;
      rsp_err   <= 1'b0;
      rsp_last  <= 1'b0;
      err_count <= '0;
    end else begin
      if (state == IDLE && req_valid) begin
        state     <= RESP;
        burst     <= req_burst;
        rsp_valid <= 1'b1;
      end else if (state == RESP && rsp_ready && rsp_last) begin
        state     <= IDLE;
        rsp_valid <= 1'b0;
      end
      if (load_en) begin
        rsp_addr <= load_idx;
        rsp_last <= ~load_burst | (load_idx == 2'd3);
        rsp_err  <= lock;
        rsp_data <= lock ? 32'd0 : load_word;
        if (lock && err_count != 8'hFF)
          err_count <= err_count + 8'd1;
      end
    end
  end

endmodule
